// File: rtl/c3_pkg.sv
// Shared constants for the C3 partial-sum accumulator slice.
package c3_pkg;
  localparam int C3_PSUM_W    = 32;
  localparam int C3_OFM_W     = 8;
  localparam int C3_BIAS_W    = 16;
  localparam int C3_OFM_MAX   = 255;
  localparam int C3_NUM_IN_CH = 6;
  localparam int C3_SHIFT     = 8;
  localparam int C3_ACC_W     = 36;
  localparam int C3_NUM_PIX   = 2;

  // Channel counter width; never collapses to zero bits for a single-channel build.
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/c3_psum_accumulator_if.sv
// Partial-sum in / feature-map out bundle between the C3 PU, accumulator and S4.
interface c3_psum_accumulator_if import c3_pkg::*; #(
  parameter int NUM_IN_CH = C3_NUM_IN_CH
);
  localparam int CNT_W = cnt_w(NUM_IN_CH);

  logic                        c3_part_valid;
  logic signed [C3_PSUM_W-1:0] c3_part_0;
  logic signed [C3_PSUM_W-1:0] c3_part_1;
  logic signed [C3_BIAS_W-1:0] c3_bias;
  logic                        acc_clear;
  logic                        c3_ofm_valid;
  logic [C3_OFM_W-1:0]         c3_ofm_0;
  logic [C3_OFM_W-1:0]         c3_ofm_1;
  logic [CNT_W-1:0]            ch_cnt;

  modport master (
    output c3_part_valid, c3_part_0, c3_part_1, c3_bias, acc_clear,
    input  c3_ofm_valid, c3_ofm_0, c3_ofm_1, ch_cnt
  );

  modport slave (
    input  c3_part_valid, c3_part_0, c3_part_1, c3_bias, acc_clear,
    output c3_ofm_valid, c3_ofm_0, c3_ofm_1, ch_cnt
  );
endinterface

// File: rtl/c3_requant.sv
// Single-pixel requantiser: round-half-up, arithmetic shift, ReLU, clamp, register.
module c3_requant import c3_pkg::*; #(
  parameter int ACC_W = C3_ACC_W,
  parameter int SHIFT = C3_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] fin,
  output logic [C3_OFM_W-1:0]     ofm
);
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(64'd1 << (SHIFT-1));
  localparam logic signed [ACC_W-1:0] OFM_MAX = ACC_W'(C3_OFM_MAX);

  logic signed [ACC_W-1:0] rnd_sum;
  logic signed [ACC_W-1:0] r;
  logic [C3_OFM_W-1:0]     sat;

  // Round towards +inf then shift; negative results go to 0, large ones pin at 255.
  always_comb begin
    rnd_sum = fin + RND;
    r       = rnd_sum >>> SHIFT;
    sat     = r[C3_OFM_W-1:0];
    if (r[ACC_W-1])        sat = '0;
    else if (r > OFM_MAX)  sat = C3_OFM_W'(C3_OFM_MAX);
  end

  // Output holds its last value between result strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ofm <= '0;
    else if (en) ofm <= sat;
  end
endmodule

// File: rtl/c3_psum_accumulator.sv
// Sums NUM_IN_CH per-channel partials for a pixel pair, adds bias, requantises to u8.
module c3_psum_accumulator import c3_pkg::*; #(
  parameter int NUM_IN_CH = C3_NUM_IN_CH,
  parameter int ACC_W     = C3_ACC_W,
  parameter int SHIFT     = C3_SHIFT
) (
  input logic                   clk,
  input logic                   rst,
  c3_psum_accumulator_if.slave  bus
);
  localparam int CNT_W   = cnt_w(NUM_IN_CH);
  localparam int NUM_PIX = C3_NUM_PIX;
  localparam int STAGES  = 2;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_IN_CH-1);

  logic [NUM_PIX-1:0][C3_PSUM_W-1:0] part;
  logic [NUM_PIX-1:0][C3_OFM_W-1:0]  ofm;
  logic [CNT_W-1:0]                  cnt;
  logic [STAGES:1]                   vld_pipe;
  logic                              last;
  logic signed [ACC_W-1:0]           bias_ext;

  assign part[0]  = bus.c3_part_0;
  assign part[1]  = bus.c3_part_1;
  assign bias_ext = {{(ACC_W-C3_BIAS_W){bus.c3_bias[C3_BIAS_W-1]}}, bus.c3_bias};

  // A clear restarts the group, so the concurrent partial is channel 0 of a new one.
  assign last = bus.c3_part_valid &&
                (bus.acc_clear ? (NUM_IN_CH == 1) : (cnt == LAST_CH));

  // Channel counter: wraps on the last partial, restarts at 1 on clear-with-partial.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (last)              cnt <= '0;
    else if (bus.c3_part_valid) cnt <= bus.acc_clear ? CNT_W'(1) : cnt + CNT_W'(1);
    else if (bus.acc_clear)     cnt <= '0;
  end

  // Stage valids: [1] = fin registered, [STAGES] = requantised output registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], last};
  end

  for (genvar g = 0; g < NUM_PIX; g++) begin : g_pix
    logic signed [ACC_W-1:0] part_ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] fin_q;

    assign part_ext = {{(ACC_W-C3_PSUM_W){part[g][C3_PSUM_W-1]}}, part[g]};
    assign base     = bus.acc_clear ? '0 : acc_q;
    assign sum      = base + part_ext;

    // Stage A: accumulate; the last partial folds in the bias and hands off to stage B.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
        fin_q <= '0;
      end else if (last) begin
        fin_q <= sum + bias_ext;
        acc_q <= '0;
      end else if (bus.c3_part_valid) begin
        acc_q <= sum;
      end else if (bus.acc_clear) begin
        acc_q <= '0;
      end
    end

    c3_requant #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_rq (
      .clk (clk),
      .rst (rst),
      .en  (vld_pipe[1]),
      .fin (fin_q),
      .ofm (ofm[g])
    );
  end

  assign bus.c3_ofm_valid = vld_pipe[STAGES];
  assign bus.c3_ofm_0     = ofm[0];
  assign bus.c3_ofm_1     = ofm[1];
  assign bus.ch_cnt       = cnt;
endmodule

// File: tb/tb_c3_psum_accumulator.sv
// Bench for c3_psum_accumulator: cycle model over integer sums plus directed literals.
module tb_c3_psum_accumulator;
  import c3_pkg::*;

  localparam int N  = 6;
  localparam int SH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c3_psum_accumulator_if #(.NUM_IN_CH(N)) bus();

  c3_psum_accumulator #(.NUM_IN_CH(N), .ACC_W(36), .SHIFT(SH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: running sums as plain integers, plus expected events keyed by cycle.
  longint ms0, ms1;
  int     mcnt;
  bit     exp_v[int];
  int     exp_o0[int];
  int     exp_o1[int];
  int     exp_cnt[int];
  int     held0, held1;
  bit     in_rst = 1'b1;
  int     last_part_cyc;
  int     sq_cyc[$];
  int     sq_o0[$];
  int     sq_o1[$];

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int requant(longint s);
    longint r;
    r = (s + (longint'(1) << (SH-1))) >>> SH;
    if (r < 0)   return 0;
    if (r > 255) return 255;
    return int'(r);
  endfunction

  task automatic drive(bit v, int p0, int p1, int b, bit clr);
    @(negedge clk); #1;
    bus.c3_part_valid = v;
    bus.c3_part_0     = p0;
    bus.c3_part_1     = p1;
    bus.c3_bias       = b[15:0];
    bus.acc_clear     = clr;
    if (clr) begin ms0 = 0; ms1 = 0; mcnt = 0; end
    if (v) begin
      ms0 += longint'(p0);
      ms1 += longint'(p1);
      mcnt++;
      last_part_cyc = cyc;
      if (mcnt == N) begin
        exp_v[cyc+2]  = 1'b1;
        exp_o0[cyc+2] = requant(ms0 + longint'(b));
        exp_o1[cyc+2] = requant(ms1 + longint'(b));
        ms0 = 0; ms1 = 0; mcnt = 0;
      end
    end
    exp_cnt[cyc+1] = mcnt;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic clr_q();
    sq_cyc.delete(); sq_o0.delete(); sq_o1.delete();
  endtask

  // Every cycle out of reset: strobe, held outputs and channel count against the model.
  always @(negedge clk) begin : cmp_p
    bit ev;
    if (!in_rst) begin
      ev = exp_v.exists(cyc);
      if (ev) begin held0 = exp_o0[cyc]; held1 = exp_o1[cyc]; end
      chk("ofm_valid", bus.c3_ofm_valid, ev);
      chk("ofm_0", bus.c3_ofm_0, held0);
      chk("ofm_1", bus.c3_ofm_1, held1);
      if (exp_cnt.exists(cyc)) chk("ch_cnt", bus.ch_cnt, exp_cnt[cyc]);
      if (bus.c3_ofm_valid) begin
        sq_cyc.push_back(cyc); sq_o0.push_back(bus.c3_ofm_0); sq_o1.push_back(bus.c3_ofm_1);
      end
    end
  end

  initial begin
    bus.c3_part_valid = 1'b0; bus.c3_part_0 = '0; bus.c3_part_1 = '0;
    bus.c3_bias = '0; bus.acc_clear = 1'b0;
    ms0 = 0; ms1 = 0; mcnt = 0; held0 = 0; held1 = 0; last_part_cyc = 0;

    repeat (2) @(negedge clk);
    chk("reset_valid", bus.c3_ofm_valid, 0);
    chk("reset_ofm_0", bus.c3_ofm_0, 0);
    chk("reset_ofm_1", bus.c3_ofm_1, 0);
    chk("reset_ch_cnt", bus.ch_cnt, 0);
    #1 rst = 1'b0;
    exp_cnt[cyc] = 0; exp_cnt[cyc+1] = 0;
    in_rst = 1'b0;

    // 1: 6 x 256 -> (1536+128)>>8 = 6; 6 x -256 -> ReLU 0
    clr_q();
    for (int i = 0; i < N; i++) drive(1'b1, 256, -256, 0, 1'b0);
    idle(4);
    chk("s1_count", sq_cyc.size(), 1);
    if (sq_cyc.size() == 1) begin
      chk("s1_ofm_0", sq_o0[0], 6);
      chk("s1_ofm_1", sq_o1[0], 0);
      chk("s1_latency", sq_cyc[0] - last_part_cyc, 2);
    end

    // 2: saturation high and low
    clr_q();
    for (int i = 0; i < N; i++) drive(1'b1, 100000, -100000, 0, 1'b0);
    idle(4);
    chk("s2_count", sq_cyc.size(), 1);
    if (sq_cyc.size() == 1) begin
      chk("s2_ofm_0", sq_o0[0], 255);
      chk("s2_ofm_1", sq_o1[0], 0);
    end

    // 3: back-to-back groups, second with bias 256 -> (3072+256+128)>>8 = 13
    clr_q();
    for (int i = 0; i < N; i++) drive(1'b1, 256, -256, 0, 1'b0);
    for (int i = 0; i < N; i++) drive(1'b1, 512, 0, 256, 1'b0);
    idle(4);
    chk("s3_count", sq_cyc.size(), 2);
    if (sq_cyc.size() == 2) begin
      chk("s3_spacing", sq_cyc[1] - sq_cyc[0], 6);
      chk("s3_ofm0_g1", sq_o0[0], 6);
      chk("s3_ofm0_g2", sq_o0[1], 13);
    end

    // 4: clear with a concurrent partial restarts the group
    clr_q();
    for (int i = 0; i < 3; i++) drive(1'b1, 1000, 0, 0, 1'b0);
    drive(1'b1, 256, 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 256, 0, 0, 1'b0);
    idle(4);
    chk("s4_count", sq_cyc.size(), 1);
    if (sq_cyc.size() == 1) chk("s4_ofm_0", sq_o0[0], 6);

    // 5: idle gaps between partials change nothing
    clr_q();
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 256, -256, 0, 1'b0);
      if (i != N-1) idle($urandom_range(0, 5));
    end
    idle(4);
    chk("s5_count", sq_cyc.size(), 1);
    if (sq_cyc.size() == 1) begin
      chk("s5_ofm_0", sq_o0[0], 6);
      chk("s5_latency", sq_cyc[0] - last_part_cyc, 2);
    end

    // 6: asynchronous reset mid-group, then a fresh group
    for (int i = 0; i < 4; i++) drive(1'b1, 256, -256, 0, 1'b0);
    @(posedge clk); #2;
    in_rst = 1'b1;
    rst = 1'b1;
    bus.c3_part_valid = 1'b0;
    bus.acc_clear = 1'b0;
    #1;
    chk("s6_rst_valid", bus.c3_ofm_valid, 0);
    chk("s6_rst_ofm_0", bus.c3_ofm_0, 0);
    chk("s6_rst_ofm_1", bus.c3_ofm_1, 0);
    chk("s6_rst_ch_cnt", bus.ch_cnt, 0);
    ms0 = 0; ms1 = 0; mcnt = 0; held0 = 0; held1 = 0;
    exp_v.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    exp_cnt[cyc] = 0; exp_cnt[cyc+1] = 0;
    in_rst = 1'b0;
    clr_q();
    for (int i = 0; i < N; i++) drive(1'b1, 256, -256, 0, 1'b0);
    idle(4);
    chk("s6_count", sq_cyc.size(), 1);
    if (sq_cyc.size() == 1) chk("s6_ofm_0", sq_o0[0], 6);

    // Random traffic: gaps, occasional clears, mixed small and full-range values
    for (int i = 0; i < 400; i++) begin
      int p0, p1, b;
      if ($urandom_range(0, 7) == 0) begin
        p0 = int'($urandom); p1 = int'($urandom);
      end else begin
        p0 = int'($urandom_range(0, 16000)) - 8000;
        p1 = int'($urandom_range(0, 16000)) - 4000;
      end
      b = int'($urandom_range(0, 65535)) - 32768;
      drive(($urandom_range(0, 3) != 0), p0, p1, b, ($urandom_range(0, 39) == 0));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
